// File: rtl/gol_controller.sv
// Sequencer for a serially-chained Game of Life cell array: loads a pattern,
// advances it a requested number of generations, then unloads it while recirculating.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting in CELLS pattern bits from in_data
// RUN    | asserting NextTimeTick once per remaining generation
// UNLOAD | presenting ArrayOut on out_data and recirculating it into DataIn
// DONE   | one-cycle completion pulse
module gol_controller #(
    parameter int CELLS = 64,
    parameter int GEN_W = 8
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             start,
    input  logic             load_en,
    input  logic [GEN_W-1:0] gen_count,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    input  logic             ArrayOut,
    output logic             Shift,
    output logic             NextTimeTick,
    output logic             DataIn,
    output logic             out_valid,
    output logic             out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(CELLS + 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(CELLS);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [GEN_W-1:0] GEN_ONE  = GEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [GEN_W-1:0] gen_cnt, gen_cnt_nxt;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gen_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            gen_cnt <= gen_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        gen_cnt_nxt  = gen_cnt;
        in_ready     = 1'b0;
        Shift        = 1'b0;
        NextTimeTick = 1'b0;
        DataIn       = 1'b0;
        out_valid    = 1'b0;
        out_data     = 1'b0;
        done         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    gen_cnt_nxt = gen_count;
                    bit_cnt_nxt = BIT_LOAD;
                    if (load_en)
                        state_nxt = S_LOAD;
                    else if (gen_count == '0)
                        state_nxt = S_UNLOAD;
                    else
                        state_nxt = S_RUN;
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    Shift       = 1'b1;
                    DataIn      = in_data;
                    bit_cnt_nxt = bit_cnt - BIT_ONE;
                    if (bit_cnt == BIT_ONE) begin
                        // a zero generation request skips RUN entirely
                        bit_cnt_nxt = BIT_LOAD;
                        state_nxt   = (gen_cnt == '0) ? S_UNLOAD : S_RUN;
                    end
                end
            end

            S_RUN: begin
                NextTimeTick = (gen_cnt != '0);
                if (gen_cnt != '0)
                    gen_cnt_nxt = gen_cnt - GEN_ONE;
                if (gen_cnt <= GEN_ONE) begin
                    bit_cnt_nxt = BIT_LOAD;
                    state_nxt   = S_UNLOAD;
                end
            end

            S_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = ArrayOut;
                if (out_ready) begin
                    // feed the outgoing bit back in so the array keeps its pattern
                    Shift       = 1'b1;
                    DataIn      = ArrayOut;
                    bit_cnt_nxt = bit_cnt - BIT_ONE;
                    if (bit_cnt == BIT_ONE)
                        state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_gol_controller.sv
// Bench for gol_controller: an 8x8 dead-boundary Life array model sits on the
// chain ports; results are compared against Life generations computed on the grid.
module tb_gol_controller;

    localparam int CELLS = 64;
    localparam int GEN_W = 8;

    logic             clock = 1'b0;
    logic             nReset = 1'b0;
    logic             start = 1'b0;
    logic             load_en = 1'b0;
    logic [GEN_W-1:0] gen_count = '0;
    logic             in_valid = 1'b0;
    logic             in_data = 1'b0;
    logic             in_ready;
    logic             ArrayOut;
    logic             Shift;
    logic             NextTimeTick;
    logic             DataIn;
    logic             out_valid;
    logic             out_data;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;
    int shift_cnt = 0;
    int tick_cnt  = 0;
    int done_cnt  = 0;

    logic [63:0] cells = '0;
    logic [63:0] exp_arr = '0;
    logic [63:0] got;
    logic [63:0] pat;
    logic        prev_stall = 1'b0;
    logic        prev_od = 1'b0;

    gol_controller #(.CELLS(CELLS), .GEN_W(GEN_W)) dut (
        .clock(clock), .nReset(nReset), .start(start), .load_en(load_en),
        .gen_count(gen_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ArrayOut(ArrayOut), .Shift(Shift),
        .NextTimeTick(NextTimeTick), .DataIn(DataIn), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // cell k sits at row k/8, column k%8; chain index 63 is the last cell
    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int r, c, rr, cc, cnt;
        n = '0;
        for (int k = 0; k < 64; k++) begin
            r = k / 8;
            c = k % 8;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++) begin
                    rr = r + dr;
                    cc = c + dc;
                    if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                        cnt += int'(g[rr*8+cc]);
                end
            n[k] = g[k] ? (cnt == 2 || cnt == 3) : (cnt == 3);
        end
        return n;
    endfunction

    function automatic logic [63:0] life_n(input logic [63:0] g, input int gens);
        logic [63:0] x;
        x = g;
        for (int i = 0; i < gens; i++) x = life_step(x);
        return x;
    endfunction

    function automatic logic [63:0] cells_of(input int a, input int b, input int c,
                                             input int d, input int e);
        logic [63:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    always @(posedge clock) begin
        if (Shift)
            cells <= {cells[62:0], DataIn};
        else if (NextTimeTick)
            cells <= life_step(cells);
    end
    assign ArrayOut = cells[63];

    always @(negedge clock) begin
        if (nReset) begin
            if (Shift) shift_cnt++;
            if (NextTimeTick) tick_cnt++;
            if (done) done_cnt++;
            n_assert++;
            assert (!(Shift && NextTimeTick)) else begin
                n_fail++;
                $error("FAIL shift_tick_excl: observed Shift=%b NextTimeTick=%b, required not both 1",
                       Shift, NextTimeTick);
            end
            n_assert++;
            assert (Shift || !DataIn) else begin
                n_fail++;
                $error("FAIL datain_idle: observed DataIn=%b with Shift=0, required 0", DataIn);
            end
            if (prev_stall && out_valid) begin
                n_assert++;
                assert (out_data === prev_od) else begin
                    n_fail++;
                    $error("FAIL out_data_stall: observed %b, required %b", out_data, prev_od);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_od    = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, {56'd0, Shift, NextTimeTick, DataIn, in_ready, out_valid, out_data, busy, done},
              64'd0);
    endtask

    // one complete job; returns the unloaded bits mapped back onto chain positions
    task automatic run_job(input logic le, input int gen, input logic [63:0] p,
                           input bit rnd, input bit poke_start, input string name,
                           output logic [63:0] res);
        int idx, cyc;
        res = '0;
        shift_cnt = 0;
        tick_cnt  = 0;
        done_cnt  = 0;
        @(posedge clock); #1;
        start = 1'b1; load_en = le; gen_count = GEN_W'(gen);
        @(posedge clock); #1;
        start = 1'b0; load_en = 1'($urandom); gen_count = GEN_W'($urandom);
        if (le) begin
            exp_arr = p;
            idx = 0;
            cyc = 0;
            while (idx < 64 && cyc < 2000) begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = p[63-idx];
                @(negedge clock);
                if (in_valid && in_ready) idx++;
                @(posedge clock); #1;
                cyc++;
            end
            in_valid = 1'b0;
            in_data  = 1'b0;
            check({name, "_load_count"}, 64'(idx), 64'd64);
        end
        exp_arr = life_n(exp_arr, gen);
        idx = 0;
        cyc = 0;
        while (idx < 64 && cyc < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke_start && (idx == 10);
            load_en   = start;
            @(negedge clock);
            if (out_valid && out_ready) begin
                res[63-idx] = out_data;
                idx++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, "_unload_count"}, 64'(idx), 64'd64);
        @(negedge clock);
        check({name, "_done_pulse"}, {62'd0, done, busy}, 64'd3);
        @(posedge clock); #1;
        @(negedge clock);
        check({name, "_idle_after"}, {60'd0, done, busy, in_ready, out_valid}, 64'd0);
        check({name, "_ticks"}, 64'(tick_cnt), 64'(gen));
        check({name, "_shifts"}, 64'(shift_cnt), le ? 64'd128 : 64'd64);
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, "_result"}, res, exp_arr);
        check({name, "_array_kept"}, cells, exp_arr);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] glider;
        int cyc;

        #3;
        check_outs_zero("reset_outputs");
        repeat (2) @(negedge clock);
        nReset = 1'b1;

        // blinker: horizontal at row 3, cols 2..4 -> vertical at col 3, rows 2..4
        run_job(1'b1, 1, cells_of(26, 27, 28, -1, -1), 1'b0, 1'b0, "blinker", got);
        check("blinker_vertical", got, cells_of(19, 27, 35, -1, -1));

        pat = {$urandom, $urandom};
        run_job(1'b1, 0, pat, 1'b0, 1'b1, "gen0", got);
        check("gen0_identity", got, pat);

        pat = {$urandom, $urandom};
        run_job(1'b1, $urandom_range(1, 3), pat, 1'b1, 1'b1, "random_hs", got);

        glider = cells_of(10, 19, 25, 26, 27);
        run_job(1'b1, 0, glider, 1'b1, 1'b0, "glider_load", got);
        run_job(1'b0, 2, 64'd0, 1'b1, 1'b0, "glider_run", got);
        check("glider_pop", 64'($countones(got)), 64'd5);
        check("glider_two_gens", got, life_n(glider, 2));

        // abandon a 5-generation job during its third generation
        tick_cnt = 0;
        done_cnt = 0;
        @(posedge clock); #1;
        start = 1'b1; load_en = 1'b0; gen_count = 8'd5;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (tick_cnt < 3 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("abort_reach_gen3", 64'(tick_cnt), 64'd3);
        #2;
        nReset = 1'b0;
        #1;
        check_outs_zero("abort_outputs");
        repeat (3) @(negedge clock);
        check_outs_zero("abort_held");
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // start presented together with reset release must be taken on the next edge
        start = 1'b1; load_en = 1'b0; gen_count = 8'd1;
        nReset = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("first_start", {62'd0, busy, NextTimeTick}, 64'd3);
        out_ready = 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b0;
        check("post_reset_done", 64'(done_cnt), 64'd1);

        pat = {$urandom, $urandom};
        run_job(1'b1, 1, pat, 1'b1, 1'b0, "post_reset_job", got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
